// File: rtl/rx_burst.sv
// rx_burst: energy-gated burst receiver (detect, preamble sync, payload capture, tail, guard); RX_BURST_BER_CHECK_EN adds the LFSR payload error counter
module rx_burst #(
  parameter logic [9:0] MAG_THRESHOLD = 10'd64,
  parameter int DETECT_SAMPLES = 16,
  parameter int DROP_SAMPLES = 32,
  parameter int PREAMBLE_MIN = 8,
  parameter int PAYLOAD_BITS = 11,
  parameter int GUARD_SAMPLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iq_valid_i,
  input  logic [8:0] rf_inphase_i,
  input  logic [8:0] rf_quadrature_i,
  input  logic       demod_bit_i,
  input  logic       demod_strobe_i,
  output logic       demod_enable_o,
  output logic       payload_bit_o,
  output logic       payload_valid_o,
  output logic       burst_done_o,
  output logic       burst_abort_o,
  output logic [7:0] bit_errors_o,
  output logic [9:0] peak_mag_o,
  output logic       is_listening_o
);
  localparam int CW = 16;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] DET_N = CW'(DETECT_SAMPLES);
  localparam logic [CW-1:0] DROP_N = CW'(DROP_SAMPLES);
  localparam logic [CW-1:0] PRE_N = CW'(PREAMBLE_MIN);
  localparam logic [CW-1:0] BITS_N = CW'(PAYLOAD_BITS);
  localparam logic [CW-1:0] GRD_N = CW'(GUARD_SAMPLES);

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    DETECT  = 6'b000010,
    SYNC    = 6'b000100,
    PAYLOAD = 6'b001000,
    TAIL    = 6'b010000,
    GUARD   = 6'b100000
  } state_t;

  state_t state, state_n;
  logic [9:0] i_ext, q_ext, i_abs, q_abs, mag_q;
  logic mag_v;
  logic [CW-1:0] det_cnt, drop_cnt, pre_cnt, bit_cnt, grd_cnt;
  logic above, below, in_burst, track, det_hit, lost, sync_hit, pay_take, last, grd_hit;

  // |I| and |Q| in 10 bits so that |-256| stays 256 without overflow
  always_comb begin
    i_ext = {rf_inphase_i[8], rf_inphase_i};
    q_ext = {rf_quadrature_i[8], rf_quadrature_i};
    i_abs = i_ext[9] ? -i_ext : i_ext;
    q_abs = q_ext[9] ? -q_ext : q_ext;
  end

  // magnitude pipeline: |I|+|Q| and its qualifier, one cycle behind the input
  always_ff @(posedge clock) begin
    if (!reset) begin
      mag_v <= 1'b0;
      mag_q <= '0;
    end else begin
      mag_v <= iq_valid_i;
      mag_q <= iq_valid_i ? i_abs + q_abs : mag_q;
    end
  end

  // state register
  always_ff @(posedge clock)
    state <= !reset ? IDLE : state_n;

  // event decode and next state; loss of energy outranks a same-cycle demod strobe
  always_comb begin
    above = mag_v && (mag_q > MAG_THRESHOLD);
    below = mag_v && !above;
    in_burst = state inside {SYNC, PAYLOAD, TAIL};
    track = in_burst || state == DETECT;
    det_hit = (state == IDLE || state == DETECT) && above && (det_cnt + ONE >= DET_N);
    lost = in_burst && below && (drop_cnt + ONE >= DROP_N);
    sync_hit = state == SYNC && demod_strobe_i && !demod_bit_i && pre_cnt >= PRE_N && !lost;
    pay_take = sync_hit || (state == PAYLOAD && demod_strobe_i && !lost);
    last = pay_take && (bit_cnt + ONE >= BITS_N);
    grd_hit = state == GUARD && mag_v && (grd_cnt + ONE >= GRD_N);
    demod_enable_o = in_burst;
    is_listening_o = state == IDLE;
    state_n = state;
    case (state)
      IDLE, DETECT: state_n = det_hit ? SYNC : above ? DETECT : below ? IDLE : state;
      SYNC:         state_n = lost ? GUARD : last ? TAIL : sync_hit ? PAYLOAD : SYNC;
      PAYLOAD:      state_n = lost ? GUARD : last ? TAIL : PAYLOAD;
      TAIL:         state_n = lost ? GUARD : TAIL;
      GUARD:        state_n = grd_hit ? IDLE : GUARD;
      default:      state_n = IDLE;
    endcase
  end

  // run counters; each is bounded by the threshold that ends its state, preamble run saturates
  always_ff @(posedge clock) begin
    if (!reset) begin
      det_cnt <= '0;
      drop_cnt <= '0;
      pre_cnt <= '0;
      bit_cnt <= '0;
      grd_cnt <= '0;
    end else begin
      det_cnt <= state_n == DETECT ? det_cnt + CW'(above) : '0;
      drop_cnt <= (state_n inside {SYNC, PAYLOAD, TAIL}) && !above ? drop_cnt + CW'(below) : '0;
      pre_cnt <= state_n != SYNC ? '0 :
                 (state == SYNC && demod_strobe_i) ? (demod_bit_i ? pre_cnt + CW'(pre_cnt < PRE_N) : '0) :
                 pre_cnt;
      bit_cnt <= state_n == PAYLOAD ? bit_cnt + CW'(pay_take) : '0;
      grd_cnt <= (state == GUARD && state_n == GUARD) ? grd_cnt + CW'(mag_v) : '0;
    end
  end

  // registered payload strobe, completion pulses and peak tracking (peak restarts at sync entry)
  always_ff @(posedge clock) begin
    if (!reset) begin
      payload_valid_o <= 1'b0;
      payload_bit_o <= 1'b0;
      burst_done_o <= 1'b0;
      burst_abort_o <= 1'b0;
      peak_mag_o <= '0;
    end else begin
      payload_valid_o <= pay_take;
      payload_bit_o <= pay_take && demod_bit_i;
      burst_done_o <= last;
      burst_abort_o <= lost && state != TAIL;
      peak_mag_o <= det_hit ? mag_q : (track && mag_v && mag_q > peak_mag_o) ? mag_q : peak_mag_o;
    end
  end

`ifdef RX_BURST_BER_CHECK_EN
  logic [7:0] lfsr;

  // reference sequence generator and saturating mismatch count, both restarted at sync entry
  always_ff @(posedge clock) begin
    if (!reset || det_hit) begin
      lfsr <= 8'h01;
      bit_errors_o <= '0;
    end else if (pay_take) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 8'h8e : 8'h00);
      bit_errors_o <= bit_errors_o + 8'(demod_bit_i != lfsr[1] && bit_errors_o != 8'hff);
    end
  end
`else
  assign bit_errors_o = '0;
`endif

endmodule

// File: tb/tb_rx_burst.sv
// tb_rx_burst: randomized burst scenarios checked against a transaction-level receiver model
module tb_rx_burst;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iq_valid_i = 1'b0;
  logic [8:0] rf_inphase_i = '0;
  logic [8:0] rf_quadrature_i = '0;
  logic demod_bit_i = 1'b0;
  logic demod_strobe_i = 1'b0;
  logic demod_enable_o, payload_bit_o, payload_valid_o, burst_done_o, burst_abort_o, is_listening_o;
  logic [7:0] bit_errors_o;
  logic [9:0] peak_mag_o;

  int n_err = 0;
  int n_chk = 0;
  int n_valid = 0;
  int n_done = 0;
  int n_abort = 0;
  int n_en = 0;
  int n_deaf = 0;
  int peak_model = 0;
  bit pay_q[$];

  rx_burst dut (
    .clock(clock),
    .reset(reset),
    .iq_valid_i(iq_valid_i),
    .rf_inphase_i(rf_inphase_i),
    .rf_quadrature_i(rf_quadrature_i),
    .demod_bit_i(demod_bit_i),
    .demod_strobe_i(demod_strobe_i),
    .demod_enable_o(demod_enable_o),
    .payload_bit_o(payload_bit_o),
    .payload_valid_o(payload_valid_o),
    .burst_done_o(burst_done_o),
    .burst_abort_o(burst_abort_o),
    .bit_errors_o(bit_errors_o),
    .peak_mag_o(peak_mag_o),
    .is_listening_o(is_listening_o)
  );

  always #5 clock = ~clock;

  // output monitor on the falling edge
  always @(negedge clock) begin
    if (payload_valid_o) begin
      n_valid++;
      pay_q.push_back(payload_bit_o);
    end
    if (burst_done_o) n_done++;
    if (burst_abort_o) n_abort++;
    if (demod_enable_o) n_en++;
    if (!is_listening_o) n_deaf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ref_seq();
    logic [7:0] l;
    logic [10:0] s;
    l = 8'h01;
    s = '0;
    for (int k = 0; k < 11; k++) begin
      s[k] = l[1];
      l = (l >> 1) ^ (l[0] ? 8'h8e : 8'h00);
    end
    return s;
  endfunction

  task automatic drive(input logic v, input logic [8:0] i, input logic [8:0] q, input logic s, input logic b);
    iq_valid_i = v;
    rf_inphase_i = i;
    rf_quadrature_i = q;
    demod_strobe_i = s;
    demod_bit_i = b;
    @(posedge clock);
    #1;
    demod_strobe_i = 1'b0;
  endtask

  // valid sample with |I|+|Q| = m, random split and signs
  task automatic samp(input int m, input logic s, input logic b);
    int a, lo, hi;
    logic [8:0] i, q;
    lo = m > 256 ? m - 256 : 0;
    hi = m < 256 ? m : 256;
    a = int'($urandom_range(hi, lo));
    i = (a == 256 || $urandom_range(1, 0) == 1) ? 9'(-a) : 9'(a);
    q = ((m - a) == 256 || $urandom_range(1, 0) == 1) ? 9'(a - m) : 9'(m - a);
    drive(1'b1, i, q, s, b);
  endtask

  task automatic energy(input bit clean, input logic s, input logic b);
    int m;
    if (clean) drive(1'b1, 9'd100, 9'd0, s, b);
    else begin
      m = int'($urandom_range(511, 65));
      if (m > peak_model) peak_model = m;
      samp(m, s, b);
    end
  endtask

  task automatic gap(input bit clean);
    int r;
    r = int'($urandom_range(7, 0));
    if (clean || r > 1) energy(clean, 1'b0, 1'b0);
    else if (r == 0) drive(1'b0, 9'($urandom), 9'($urandom), 1'b0, 1'b0);
    else samp(int'($urandom_range(64, 0)), 1'b0, 1'b0);
  endtask

  task automatic low(input bit zero, input logic s, input logic b);
    if (zero) drive(1'b1, 9'd0, 9'd0, s, b);
    else samp(int'($urandom_range(64, 0)), s, b);
  endtask

  task automatic run_burst(input bit clean, input int false_ones, input int pre_ones,
                           input logic [10:0] err_mask, input int fade_after, input int first_mag,
                           input string nm);
    int v0, d0, a0, q0, n_pay, exp_errs;
    logic [10:0] exp_bits, exp_vec, got;
    bit bits[$];
    v0 = n_valid;
    d0 = n_done;
    a0 = n_abort;
    q0 = pay_q.size();
    exp_bits = ref_seq() ^ err_mask;
    n_pay = fade_after < 0 ? 11 : fade_after + 1;
    exp_vec = '0;
    for (int k = 0; k < n_pay; k++) exp_vec[k] = exp_bits[k];
    exp_errs = $countones(err_mask & exp_vec | err_mask & ~exp_vec & ((11'h7ff) >> (11 - n_pay)));
`ifndef RX_BURST_BER_CHECK_EN
    exp_errs = 0;
`endif
    repeat (20) samp(int'($urandom_range(64, 0)), 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      if (clean) drive(1'b1, 9'd100, 9'd0, 1'b0, 1'b0);
      else samp(int'($urandom_range(200, 65)), 1'b0, 1'b0);
    peak_model = clean ? 100 : first_mag;
    if (clean) drive(1'b1, 9'd100, 9'd0, 1'b0, 1'b0);
    else samp(first_mag, 1'b0, 1'b0);
    repeat (2) energy(clean, 1'b0, 1'b0);
    check({nm, " sync_enable"}, 32'({demod_enable_o, is_listening_o}), 32'(2'b10));
    for (int k = 0; k < false_ones; k++) bits.push_back(1'b1);
    if (false_ones >= 0) bits.push_back(1'b0);
    repeat (pre_ones) bits.push_back(1'b1);
    for (int k = 0; k < n_pay; k++) bits.push_back(exp_bits[k]);
    foreach (bits[k]) begin
      energy(clean, 1'b1, bits[k]);
      repeat ($urandom_range(3, 1)) gap(clean);
    end
    if (fade_after < 0) begin
      energy(clean, 1'b1, 1'($urandom_range(1, 0)));
      energy(clean, 1'b1, 1'($urandom_range(1, 0)));
    end
    energy(clean, 1'b0, 1'b0);
    repeat (32) low(fade_after >= 0, 1'b0, 1'b0);
    low(fade_after >= 0, 1'b1, 1'($urandom_range(1, 0)));
    repeat (62) low(fade_after >= 0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check({nm, " guard_63"}, 32'(is_listening_o), 32'd0);
    low(fade_after >= 0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check({nm, " guard_64"}, 32'({is_listening_o, demod_enable_o}), 32'(2'b10));
    got = '0;
    for (int k = 0; k < 11; k++) if (q0 + k < pay_q.size()) got[k] = pay_q[q0 + k];
    check({nm, " valid_count"}, 32'(n_valid - v0), 32'(n_pay));
    check({nm, " payload_bits"}, 32'(got), 32'(exp_vec));
    check({nm, " done_count"}, 32'(n_done - d0), 32'(fade_after < 0));
    check({nm, " abort_count"}, 32'(n_abort - a0), 32'(fade_after >= 0));
    check({nm, " bit_errors"}, 32'(bit_errors_o), 32'(exp_errs));
    check({nm, " peak"}, 32'(peak_mag_o), 32'(peak_model));
  endtask

  initial begin
    int e0, d0, a0, v0, b0, f, p, fa;
    logic [10:0] mask;
    repeat (3) drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check("reset_flags", 32'({demod_enable_o, payload_bit_o, payload_valid_o, burst_done_o, burst_abort_o, is_listening_o}), 32'(6'b000001));
    check("reset_errs_peak", 32'({bit_errors_o, peak_mag_o}), 32'd0);
    reset = 1'b1;

    e0 = n_en; b0 = n_deaf; v0 = n_valid; d0 = n_done + n_abort;
    repeat (1000) samp(int'($urandom_range(64, 0)), 1'($urandom_range(3, 0) == 0), 1'($urandom_range(1, 0)));
    drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check("idle_not_listening", 32'(n_deaf - b0), 32'd0);
    check("idle_enable", 32'(n_en - e0), 32'd0);
    check("idle_pulses", 32'(n_valid - v0 + n_done + n_abort - d0), 32'd0);

    e0 = n_en;
    repeat (2) begin
      repeat (15) samp(int'($urandom_range(511, 65)), 1'b0, 1'b0);
      samp(int'($urandom_range(64, 0)), 1'b0, 1'b0);
    end
    drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check("near_miss_enable", 32'(n_en - e0), 32'd0);
    check("near_miss_listen", 32'(is_listening_o), 32'd1);

    run_burst(1'b1, -1, 10, 11'h000, -1, 100, "clean");
    run_burst(1'b1, -1, 10, 11'h088, -1, 100, "bit_err");
    run_burst(1'b0, 5, 10, 11'h000, -1, int'($urandom_range(511, 300)), "short_pre");
    run_burst(1'b0, -1, 10, 11'h000, 4, int'($urandom_range(511, 300)), "fade");
    run_burst(1'b0, 7, 8, 11'h000, -1, 512, "max_mag");
    for (int r = 0; r < 6; r++) begin
      f = int'($urandom_range(8, 0)) - 1;
      p = int'($urandom_range(12, 8));
      mask = 11'($urandom) & 11'h7fe;
      fa = $urandom_range(1, 0) == 1 ? -1 : int'($urandom_range(9, 0));
      run_burst(1'b0, f, p, mask, fa, int'($urandom_range(511, 300)), $sformatf("rand%0d", r));
    end

    repeat (20) samp(int'($urandom_range(64, 0)), 1'b0, 1'b0);
    repeat (16) samp(int'($urandom_range(200, 65)), 1'b0, 1'b0);
    repeat (3) energy(1'b0, 1'b0, 1'b0);
    repeat (10) begin energy(1'b0, 1'b1, 1'b1); gap(1'b1); end
    energy(1'b0, 1'b1, 1'b0);
    repeat (3) begin gap(1'b1); energy(1'b0, 1'b1, 1'b1); end
    repeat (2) gap(1'b1);
    check("pre_reset_payload", 32'(demod_enable_o), 32'd1);
    v0 = n_valid; d0 = n_done; a0 = n_abort;
    reset = 1'b0;
    energy(1'b0, 1'b1, 1'b1);
    check("midreset_flags", 32'({demod_enable_o, payload_bit_o, payload_valid_o, burst_done_o, burst_abort_o, is_listening_o}), 32'(6'b000001));
    check("midreset_errs_peak", 32'({bit_errors_o, peak_mag_o}), 32'd0);
    reset = 1'b1;
    repeat (100) samp(int'($urandom_range(64, 0)), 1'($urandom_range(1, 0)), 1'b0);
    drive(1'b0, 9'd0, 9'd0, 1'b0, 1'b0);
    check("midreset_pulses", 32'(n_valid - v0 + n_done - d0 + n_abort - a0), 32'd0);
    check("midreset_listen", 32'(is_listening_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
